id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register directly upstream of the 32-bit ALU. Accepts decoded instrs from ID,

---
 rtl/id_ex_operand_stage_pkg.sv | 38 +++
 rtl/id_ex_operand_stage_alu_ctrl_decode.sv | 69 ++++++
 rtl/id_ex_operand_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared opcode/funct encodings, ALU operation codes and the decoded-control bundle
// used by the ID/EX operand stage and its ALU-control decoder.
package id_ex_operand_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RIDX_DEF = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10
  } alu_op_e;

  typedef struct packed {
    alu_op_e operation;
    logic    binvert;
    logic    cin;
    logic    imm_sel;
    logic    zext;
    logic    reg_write;
    logic    rt_used;
    logic    illegal;
  } alu_ctrl_t;

endpackage

// File: rtl/id_ex_operand_stage_alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU controls, immediate select and hazard hints.
// Zero latency; no flow control (pure function of the instruction fields).
module id_ex_operand_stage_alu_ctrl_decode
  import id_ex_operand_stage_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output alu_ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl           = '0;
    o_ctrl.operation = ALU_AND;
    case (i_opcode)
      OP_RTYPE: begin
        // R-type always reads rt, even when the funct turns out to be unsupported
        o_ctrl.rt_used = 1'b1;
        case (i_funct)
          FN_ADD: begin
            o_ctrl.operation = ALU_ADD;
            o_ctrl.reg_write = 1'b1;
          end
          FN_SUB: begin
            o_ctrl.operation = ALU_ADD;
            o_ctrl.binvert   = 1'b1;
            o_ctrl.cin       = 1'b1;
            o_ctrl.reg_write = 1'b1;
          end
          FN_AND: o_ctrl.reg_write = 1'b1;
          FN_OR: begin
            o_ctrl.operation = ALU_OR;
            o_ctrl.reg_write = 1'b1;
          end
          default: o_ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW: begin
        o_ctrl.operation = ALU_ADD;
        o_ctrl.imm_sel   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_ANDI: begin
        o_ctrl.imm_sel   = 1'b1;
        o_ctrl.zext      = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_ORI: begin
        o_ctrl.operation = ALU_OR;
        o_ctrl.imm_sel   = 1'b1;
        o_ctrl.zext      = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_SW: begin
        o_ctrl.operation = ALU_ADD;
        o_ctrl.imm_sel   = 1'b1;
        o_ctrl.rt_used   = 1'b1;
      end
      OP_BEQ: begin
        // Compare as rs - rt; the branch unit looks at the ALU zero flag
        o_ctrl.operation = ALU_ADD;
        o_ctrl.binvert   = 1'b1;
        o_ctrl.cin       = 1'b1;
        o_ctrl.rt_used   = 1'b1;
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register feeding the ALU: decode, EX/MEM-over-MEM/WB forwarding, load-use stall.
// One-cycle latency; valid/ready handshake, holds all outputs while out_ready is low.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RIDX = RIDX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_opcode,
  input  logic [5:0]      in_funct,
  input  logic [15:0]     in_imm,
  input  logic [RIDX-1:0] in_rs,
  input  logic [RIDX-1:0] in_rt,
  input  logic [RIDX-1:0] in_rd,
  input  logic [XLEN-1:0] in_rs_data,
  input  logic [XLEN-1:0] in_rt_data,
  input  logic            exm_wr,
  input  logic            exm_load,
  input  logic [RIDX-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            mwb_wr,
  input  logic [RIDX-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic            alu_binvert,
  output logic            alu_cin,
  output logic [1:0]      alu_operation,
  output logic [RIDX-1:0] out_rd,
  output logic            out_reg_write,
  output logic [XLEN-1:0] out_store_data,
  output logic            out_illegal,
  output logic            stall
);

  alu_ctrl_t       w_ctrl;
  logic [XLEN-1:0] w_rs_fwd;
  logic [XLEN-1:0] w_rt_fwd;
  logic [XLEN-1:0] w_imm_ext;
  logic            w_stall;
  logic            w_capture;

  logic            r_valid;
  logic [XLEN-1:0] r_in1;
  logic [XLEN-1:0] r_in2;
  logic            r_binvert;
  logic            r_cin;
  logic [1:0]      r_operation;
  logic [RIDX-1:0] r_rd;
  logic            r_reg_write;
  logic [XLEN-1:0] r_store_data;
  logic            r_illegal;

  id_ex_operand_stage_alu_ctrl_decode u_decode (
    .i_opcode (in_opcode),
    .i_funct  (in_funct),
    .o_ctrl   (w_ctrl)
  );

  // $0 is never forwarded; the younger EX/MEM result beats MEM/WB
  always_comb begin
    w_rs_fwd = in_rs_data;
    if (exm_wr && (exm_rd == in_rs) && (in_rs != '0)) begin
      w_rs_fwd = exm_data;
    end else if (mwb_wr && (mwb_rd == in_rs) && (in_rs != '0)) begin
      w_rs_fwd = mwb_data;
    end
  end

  always_comb begin
    w_rt_fwd = in_rt_data;
    if (exm_wr && (exm_rd == in_rt) && (in_rt != '0)) begin
      w_rt_fwd = exm_data;
    end else if (mwb_wr && (mwb_rd == in_rt) && (in_rt != '0)) begin
      w_rt_fwd = mwb_data;
    end
  end

  assign w_imm_ext = w_ctrl.zext ? {{(XLEN-16){1'b0}}, in_imm}
                                 : {{(XLEN-16){in_imm[15]}}, in_imm};

  assign w_stall = in_valid && exm_load && (exm_rd != '0) &&
                   ((exm_rd == in_rs) || ((exm_rd == in_rt) && w_ctrl.rt_used));

  // Flush does not gate ready: ID squashes its own copy, the handshake simply discards it here
  assign in_ready  = (!r_valid || out_ready) && !w_stall;
  assign w_capture = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_in1        <= '0;
      r_in2        <= '0;
      r_binvert    <= 1'b0;
      r_cin        <= 1'b0;
      r_operation  <= 2'b00;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_store_data <= '0;
      r_illegal    <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_capture) begin
        r_in1        <= w_rs_fwd;
        r_in2        <= w_ctrl.imm_sel ? w_imm_ext : w_rt_fwd;
        r_binvert    <= w_ctrl.binvert;
        r_cin        <= w_ctrl.cin;
        r_operation  <= w_ctrl.operation;
        r_rd         <= in_rd;
        r_reg_write  <= w_ctrl.reg_write;
        r_store_data <= w_rt_fwd;
        r_illegal    <= w_ctrl.illegal;
      end
    end
  end

  assign out_valid      = r_valid;
  assign alu_in1        = r_in1;
  assign alu_in2        = r_in2;
  assign alu_binvert    = r_binvert;
  assign alu_cin        = r_cin;
  assign alu_operation  = r_operation;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_reg_write;
  assign out_store_data = r_store_data;
  assign out_illegal    = r_illegal;
  assign stall          = w_stall;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: vector table through a scoreboard, plus hand sequences
// for load-use stall, backpressure hold, flush and asynchronous reset.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [5:0]  in_opcode, in_funct;
  logic [15:0] in_imm;
  logic [4:0]  in_rs, in_rt, in_rd, exm_rd, mwb_rd, out_rd;
  logic [31:0] in_rs_data, in_rt_data, exm_data, mwb_data;
  logic        exm_wr, exm_load, mwb_wr;
  logic        out_valid, out_ready;
  logic [31:0] alu_in1, alu_in2, out_store_data;
  logic        alu_binvert, alu_cin, out_reg_write, out_illegal, stall;
  logic [1:0]  alu_operation;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .exm_wr(exm_wr), .exm_load(exm_load), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_binvert(alu_binvert), .alu_cin(alu_cin), .alu_operation(alu_operation),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_store_data(out_store_data), .out_illegal(out_illegal), .stall(stall)
  );

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic        bin;
    logic        cin;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] st;
    logic        ill;
  } res_t;

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic        ew;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] md;
    res_t        exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  vec_t vb;
  res_t act, cur_exp;
  res_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_out = 0;

  assign act = {alu_in1, alu_in2, alu_binvert, alu_cin, alu_operation,
                out_rd, out_reg_write, out_store_data, out_illegal};

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  task automatic apply(input vec_t x);
    in_valid   = 1'b1;
    in_opcode  = x.opc;  in_funct = x.fn;  in_imm = x.imm;
    in_rs      = x.rs;   in_rt    = x.rt;  in_rd  = x.rd;
    in_rs_data = x.rsd;  in_rt_data = x.rtd;
    exm_wr     = x.ew;   exm_rd   = x.erd; exm_data = x.ed; exm_load = 1'b0;
    mwb_wr     = x.mw;   mwb_rd   = x.mrd; mwb_data = x.md;
    cur_exp    = x.exp;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    exm_wr   = 1'b0;
    exm_load = 1'b0;
    mwb_wr   = 1'b0;
  endtask

  // Scoreboard: push on accepted input, pop and compare on consumed output
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%h expected=no_output", act);
        end else begin
          chk($sformatf("sb_out%0d", n_out), 128'(act), 128'(sb_q.pop_front()));
          n_out++;
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
  end

  initial begin
    //          opc    fn     imm       rs    rt    rd    rs_data        rt_data        ew   erd   ed           mw   mrd   md            in1            in2            bin  cin  op     rd     rw   store          ill
    vecs[0]  = '{6'h00, 6'h22, 16'h0000, 5'd1, 5'd2, 5'd3, 32'd5,         32'd3,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'd5,         32'd3,         1'b1, 1'b1, 2'b10, 5'd3,  1'b1, 32'd3,         1'b0}};
    vecs[1]  = '{6'h00, 6'h20, 16'h0000, 5'd1, 5'd2, 5'd4, 32'h10,        32'h20,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'h10,        32'h20,        1'b0, 1'b0, 2'b10, 5'd4,  1'b1, 32'h20,        1'b0}};
    vecs[2]  = '{6'h00, 6'h24, 16'h0000, 5'd3, 5'd4, 5'd5, 32'hF0F0,      32'hFF00,      1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'hF0F0,      32'hFF00,      1'b0, 1'b0, 2'b00, 5'd5,  1'b1, 32'hFF00,      1'b0}};
    vecs[3]  = '{6'h00, 6'h25, 16'h0000, 5'd3, 5'd4, 5'd6, 32'hF0F0,      32'hFF00,      1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'hF0F0,      32'hFF00,      1'b0, 1'b0, 2'b01, 5'd6,  1'b1, 32'hFF00,      1'b0}};
    vecs[4]  = '{6'h00, 6'h20, 16'h0000, 5'd4, 5'd2, 5'd8, 32'h11,        32'h22,        1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB, res_t'{32'hAA,        32'h22,        1'b0, 1'b0, 2'b10, 5'd8,  1'b1, 32'h22,        1'b0}};
    vecs[5]  = '{6'h00, 6'h20, 16'h0000, 5'd4, 5'd6, 5'd9, 32'h11,        32'h22,        1'b1, 5'd4, 32'hAA, 1'b1, 5'd6, 32'hBB, res_t'{32'hAA,        32'hBB,        1'b0, 1'b0, 2'b10, 5'd9,  1'b1, 32'hBB,        1'b0}};
    vecs[6]  = '{6'h00, 6'h20, 16'h0000, 5'd0, 5'd0, 5'd10, 32'h33,       32'h44,        1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, res_t'{32'h33,        32'h44,        1'b0, 1'b0, 2'b10, 5'd10, 1'b1, 32'h44,        1'b0}};
    vecs[7]  = '{6'h0D, 6'h00, 16'hFFFF, 5'd1, 5'd2, 5'd2, 32'h12340000,  32'h77,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'h12340000,  32'h0000FFFF,  1'b0, 1'b0, 2'b01, 5'd2,  1'b1, 32'h77,        1'b0}};
    vecs[8]  = '{6'h08, 6'h00, 16'hFFFF, 5'd1, 5'd3, 5'd3, 32'd1,         32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'd1,         32'hFFFFFFFF,  1'b0, 1'b0, 2'b10, 5'd3,  1'b1, 32'h0,         1'b0}};
    vecs[9]  = '{6'h0C, 6'h00, 16'h8000, 5'd1, 5'd3, 5'd3, 32'hFFFFFFFF,  32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'hFFFFFFFF,  32'h00008000,  1'b0, 1'b0, 2'b00, 5'd3,  1'b1, 32'h0,         1'b0}};
    vecs[10] = '{6'h23, 6'h00, 16'h8004, 5'd1, 5'd3, 5'd3, 32'h100,       32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'h100,       32'hFFFF8004,  1'b0, 1'b0, 2'b10, 5'd3,  1'b1, 32'h0,         1'b0}};
    vecs[11] = '{6'h2B, 6'h00, 16'h0010, 5'd1, 5'd5, 5'd5, 32'h200,       32'hDEAD,      1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hCAFE, res_t'{32'h200,     32'h10,        1'b0, 1'b0, 2'b10, 5'd5,  1'b0, 32'hCAFE,      1'b0}};
    vecs[12] = '{6'h04, 6'h00, 16'h0008, 5'd1, 5'd2, 5'd0, 32'd9,         32'd9,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'd9,         32'd9,         1'b1, 1'b1, 2'b10, 5'd0,  1'b0, 32'd9,         1'b0}};
    vecs[13] = '{6'h3F, 6'h00, 16'h0000, 5'd1, 5'd2, 5'd3, 32'd5,         32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'd5,         32'h0,         1'b0, 1'b0, 2'b00, 5'd3,  1'b0, 32'h0,         1'b1}};
    vecs[14] = '{6'h00, 6'h3F, 16'h0000, 5'd1, 5'd2, 5'd3, 32'd5,         32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  res_t'{32'd5,         32'h0,         1'b0, 1'b0, 2'b00, 5'd3,  1'b0, 32'h0,         1'b1}};
    vecs[15] = '{6'h00, 6'h20, 16'h0000, 5'd4, 5'd2, 5'd1, 32'h11,        32'h22,        1'b0, 5'd4, 32'hAA, 1'b0, 5'd2, 32'hBB, res_t'{32'h11,        32'h22,        1'b0, 1'b0, 2'b10, 5'd1,  1'b1, 32'h22,        1'b0}};
    // Load-use victim: add $4,$7,$2 whose rs comes from a load in EX/MEM
    vb       = '{6'h00, 6'h20, 16'h0000, 5'd7, 5'd2, 5'd4, 32'h70,        32'd2,         1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'h0,  res_t'{32'h55,        32'd2,         1'b0, 1'b0, 2'b10, 5'd4,  1'b1, 32'd2,         1'b0}};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    apply(vecs[0]);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 128'({out_valid, act}), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      apply(vecs[i]);
    end
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;

    // Load-use: one bubble, then accept with the forwarded load result
    apply(vecs[1]);
    @(posedge clk); #1;
    apply(vb);
    exm_load = 1'b1;
    #1;
    chk("lu_stall", 128'({stall, in_ready, out_valid}), 128'(3'b101));
    @(posedge clk); #1;
    exm_load = 1'b0;
    #1;
    chk("lu_bubble", 128'({stall, in_ready, out_valid}), 128'(3'b010));
    @(posedge clk); #1;
    chk("lu_accept", 128'(out_valid), 128'(1));
    in_valid = 1'b1; in_opcode = 6'h08; in_rs = 5'd1; in_rt = 5'd7;
    exm_wr = 1'b1; exm_load = 1'b1; exm_rd = 5'd7;
    #1;
    chk("lu_rt_unused", 128'(stall), 128'(0));
    in_opcode = 6'h00; in_funct = 6'h20;
    #1;
    chk("lu_rt_used", 128'(stall), 128'(1));
    exm_rd = 5'd0; in_rs = 5'd0; in_rt = 5'd0;
    #1;
    chk("lu_rd_zero", 128'(stall), 128'(0));
    idle();

    // Backpressure hold, then flush of the held instruction
    @(posedge clk); #1;
    apply(vecs[3]);
    @(posedge clk); #1;
    out_ready = 1'b0;
    apply(vecs[0]);
    #1;
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_hold0", 128'({out_valid, act}), 128'({1'b1, vecs[3].exp}));
    @(posedge clk); #1;
    chk("bp_hold1", 128'({out_valid, act}), 128'({1'b1, vecs[3].exp}));
    @(posedge clk); #1;
    chk("bp_hold2", 128'({out_valid, act}), 128'({1'b1, vecs[3].exp}));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    chk("flush_drop", 128'(out_valid), 128'(0));
    apply(vecs[1]);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    chk("flush_discard", 128'(out_valid), 128'(0));

    // Asynchronous reset with an instruction sitting in the register
    @(posedge clk); #1;
    apply(vecs[0]);
    @(posedge clk); #1;
    idle();
    chk("rst_pre_valid", 128'(out_valid), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 128'({out_valid, act}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    @(posedge clk); #1;
    apply(vecs[7]);
    @(posedge clk); #1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 128'(sb_q.size()), 128'(0));
    chk("out_count", 128'(n_out), 128'(NV + 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
